// File: rtl/amm_arb_pkg.sv
// Shared definitions for the two-port Avalon-MM arbiter.
package amm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned BEW = 4;

endpackage

// File: rtl/amm_arb_rr_pick.sv
// Combinational winner selection for two requesters (round-robin or fixed priority).
module amm_arb_rr_pick #(
   parameter int P_ROUND_ROBIN = 1
) (
   input  logic [1:0] i_req,
   input  logic       i_lg,
   output logic       o_winner,
   output logic       o_valid
);

   always_comb begin
      o_valid  = |i_req;
      o_winner = 1'b0;
      case (i_req)
         2'b10:   o_winner = 1'b1;
         // On a tie, round-robin hands the grant to the port that did not win last.
         2'b11:   o_winner = (P_ROUND_ROBIN != 0) ? ~i_lg : 1'b0;
         default: o_winner = 1'b0;
      endcase
   end

endmodule

// File: rtl/amm_arbiter2.sv
// Two-requester Avalon-MM arbiter: one transfer per grant, shared master port muxed from the owner.
module amm_arbiter2
   import amm_arb_pkg::*;
#(
   parameter int P_ROUND_ROBIN = 1
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [AW-1:0]        s0_address,
   input  logic [AW-1:0]        s1_address,
   input  logic [DW-1:0]        s0_writedata,
   input  logic [DW-1:0]        s1_writedata,
   input  logic [BEW-1:0]       s0_byteenable,
   input  logic [BEW-1:0]       s1_byteenable,
   input  logic                 s0_write,
   input  logic                 s1_write,
   input  logic                 s0_read,
   input  logic                 s1_read,
   output logic [DW-1:0]        s0_readdata,
   output logic [DW-1:0]        s1_readdata,
   output logic                 s0_waitrequest,
   output logic                 s1_waitrequest,
   output logic [AW-1:0]        m_address,
   output logic [DW-1:0]        m_writedata,
   output logic [BEW-1:0]       m_byteenable,
   output logic                 m_write,
   output logic                 m_read,
   input  logic [DW-1:0]        m_readdata,
   input  logic                 m_waitrequest
);

   arb_state_t r_state;
   arb_state_t w_state_nxt;
   logic       r_lg;
   logic [1:0] w_req;
   logic       w_winner;
   logic       w_valid;
   logic       w_gnt0;
   logic       w_gnt1;

   assign w_req = {s1_read | s1_write, s0_read | s0_write};

   amm_arb_rr_pick #(
      .P_ROUND_ROBIN(P_ROUND_ROBIN)
   ) u_pick (
      .i_req    (w_req),
      .i_lg     (r_lg),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state <= IDLE;
         r_lg    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_valid)
            r_lg <= w_winner;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_valid) w_state_nxt = w_winner ? GNT1 : GNT0;
         // Leave on completion, or early if the owner withdrew its request.
         GNT0: if (!w_req[0] || !m_waitrequest) w_state_nxt = IDLE;
         GNT1: if (!w_req[1] || !m_waitrequest) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Reset forces r_state to IDLE asynchronously, so commands drop without waiting for aclk.
   always_comb begin
      w_gnt0 = (r_state == GNT0);
      w_gnt1 = (r_state == GNT1);

      m_address      = w_gnt1 ? s1_address    : s0_address;
      m_writedata    = w_gnt1 ? s1_writedata  : s0_writedata;
      m_byteenable   = w_gnt1 ? s1_byteenable : s0_byteenable;
      m_read         = (w_gnt0 & s0_read)  | (w_gnt1 & s1_read);
      m_write        = (w_gnt0 & s0_write) | (w_gnt1 & s1_write);

      s0_waitrequest = ~(w_gnt0 & ~m_waitrequest);
      s1_waitrequest = ~(w_gnt1 & ~m_waitrequest);
      s0_readdata    = m_readdata;
      s1_readdata    = m_readdata;
   end

endmodule

// File: tb/tb_amm_arbiter2.sv
// Bench for amm_arbiter2: round-robin and fixed-priority instances share stimulus, checked against a grant-owner model.
module tb_amm_arbiter2;

   logic        aclk;
   logic        areset;
   logic [31:0] s0_address, s1_address, s0_writedata, s1_writedata;
   logic [3:0]  s0_byteenable, s1_byteenable;
   logic        s0_write, s1_write, s0_read, s1_read;
   logic [31:0] m_readdata;
   logic        m_waitrequest;

   logic [31:0] m_addr [2];
   logic [31:0] m_wd   [2];
   logic [31:0] rd0    [2];
   logic [31:0] rd1    [2];
   logic [3:0]  m_be   [2];
   logic        m_rd   [2];
   logic        m_wr   [2];
   logic        w0     [2];
   logic        w1     [2];

   int n_chk  = 0;
   int n_pass = 0;
   // Index 0 = round-robin instance, 1 = fixed-priority instance; owner -1 means no grant.
   int owner [2] = '{-1, -1};
   int last  [2] = '{1, 1};
   int log_rr[$];
   int log_fp[$];

   amm_arbiter2 #(.P_ROUND_ROBIN(1)) dut_rr (
      .aclk(aclk), .areset(areset),
      .s0_address(s0_address), .s1_address(s1_address),
      .s0_writedata(s0_writedata), .s1_writedata(s1_writedata),
      .s0_byteenable(s0_byteenable), .s1_byteenable(s1_byteenable),
      .s0_write(s0_write), .s1_write(s1_write), .s0_read(s0_read), .s1_read(s1_read),
      .s0_readdata(rd0[0]), .s1_readdata(rd1[0]),
      .s0_waitrequest(w0[0]), .s1_waitrequest(w1[0]),
      .m_address(m_addr[0]), .m_writedata(m_wd[0]), .m_byteenable(m_be[0]),
      .m_write(m_wr[0]), .m_read(m_rd[0]),
      .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
   );

   amm_arbiter2 #(.P_ROUND_ROBIN(0)) dut_fp (
      .aclk(aclk), .areset(areset),
      .s0_address(s0_address), .s1_address(s1_address),
      .s0_writedata(s0_writedata), .s1_writedata(s1_writedata),
      .s0_byteenable(s0_byteenable), .s1_byteenable(s1_byteenable),
      .s0_write(s0_write), .s1_write(s1_write), .s0_read(s0_read), .s1_read(s1_read),
      .s0_readdata(rd0[1]), .s1_readdata(rd1[1]),
      .s0_waitrequest(w0[1]), .s1_waitrequest(w1[1]),
      .m_address(m_addr[1]), .m_writedata(m_wd[1]), .m_byteenable(m_be[1]),
      .m_write(m_wr[1]), .m_read(m_rd[1]),
      .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Model: who owns the master and who won last; one transfer per grant.
   always @(posedge aclk or posedge areset) begin : model
      int nxt;
      logic r0, r1, ro;
      r0 = s0_read | s0_write;
      r1 = s1_read | s1_write;
      for (int k = 0; k < 2; k++) begin
         if (areset) begin
            owner[k] <= -1;
            last[k]  <= 1;
         end else if (owner[k] < 0) begin
            if (r0 && r1)  nxt = (k == 0) ? 1 - last[k] : 0;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
            else           nxt = -1;
            owner[k] <= nxt;
            if (nxt >= 0) last[k] <= nxt;
         end else begin
            ro = (owner[k] == 0) ? r0 : r1;
            if (!ro || !m_waitrequest) owner[k] <= -1;
         end
      end
   end

   always @(negedge aclk) begin : compare
      int o;
      logic e_rd, e_wr, e_w0, e_w1;
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_be;
      for (int k = 0; k < 2; k++) begin
         o      = owner[k];
         e_rd   = (o == 0) ? s0_read  : (o == 1) ? s1_read  : 1'b0;
         e_wr   = (o == 0) ? s0_write : (o == 1) ? s1_write : 1'b0;
         e_addr = (o == 1) ? s1_address    : s0_address;
         e_wd   = (o == 1) ? s1_writedata  : s0_writedata;
         e_be   = (o == 1) ? s1_byteenable : s0_byteenable;
         e_w0   = !(o == 0 && !m_waitrequest);
         e_w1   = !(o == 1 && !m_waitrequest);
         chk($sformatf("bus%0d", k), {m_addr[k], m_wd[k], m_be[k], m_rd[k], m_wr[k]},
             {e_addr, e_wd, e_be, e_rd, e_wr});
         chk($sformatf("wait%0d", k), {w0[k], w1[k]}, {e_w0, e_w1});
         chk($sformatf("rdata%0d", k), {rd0[k], rd1[k]}, {m_readdata, m_readdata});
         if (!w0[k] && (m_rd[k] || m_wr[k])) begin
            if (k == 0) log_rr.push_back(0); else log_fp.push_back(0);
         end
         if (!w1[k] && (m_rd[k] || m_wr[k])) begin
            if (k == 0) log_rr.push_back(1); else log_fp.push_back(1);
         end
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge aclk);
   endtask

   task automatic pulse_reset();
      areset = 1'b1;
      #2;
      areset = 1'b0;
   endtask

   initial begin : stim
      int exp_rr [4];
      exp_rr = '{0, 1, 0, 1};
      areset = 1'b1;
      s0_address = '0; s1_address = '0; s0_writedata = '0; s1_writedata = '0;
      s0_byteenable = 4'hF; s1_byteenable = 4'hF;
      s0_write = 0; s1_write = 0; s0_read = 0; s1_read = 0;
      m_readdata = '0; m_waitrequest = 1'b1;

      tick(); tick(); at_neg();
      chk("rst_rr", {m_rd[0], m_wr[0], w0[0], w1[0]}, 4'b0011);
      chk("rst_fp", {m_rd[1], m_wr[1], w0[1], w1[1]}, 4'b0011);
      tick();
      areset = 1'b0;

      // Single read, slave stalls two cycles
      s0_read = 1; s0_address = 32'h100; m_waitrequest = 1;
      at_neg(); chk("rd_c0", m_rd[0], 1'b0);
      tick(); at_neg(); chk("rd_c1", {m_rd[0], w0[0], w1[0]}, 3'b111);
      tick(); at_neg(); chk("rd_c2", {m_rd[0], w0[0], w1[0]}, 3'b111);
      tick(); m_waitrequest = 0; m_readdata = 32'hDEADBEEF;
      at_neg(); chk("rd_c3", {m_rd[0], w0[0], w1[0]}, 3'b101);
      chk("rd_data", rd0[0], 32'hDEADBEEF);
      chk("rd_addr", m_addr[0], 32'h100);
      tick(); s0_read = 0; m_waitrequest = 1; m_readdata = '0;
      at_neg(); chk("rd_c4", {m_rd[0], w0[0]}, 2'b01);

      // Simultaneous writes from reset, held for four transfers
      tick(); pulse_reset();
      log_rr.delete(); log_fp.delete();
      s0_write = 1; s0_address = 32'h10; s0_writedata = 32'h11;
      s1_write = 1; s1_address = 32'h20; s1_writedata = 32'h22;
      m_waitrequest = 0;
      tick(); at_neg();
      chk("sim_c1", {m_addr[0], m_wr[0], w0[0]}, {32'h10, 1'b1, 1'b0});
      tick(); tick(); at_neg();
      chk("sim_c3_rr", {m_addr[0], m_wd[0], w1[0]}, {32'h20, 32'h22, 1'b0});
      chk("sim_c3_fp", {m_addr[1], w0[1]}, {32'h10, 1'b0});
      repeat (5) tick();
      s0_write = 0; s1_write = 0;
      at_neg();
      chk("order_rr_n", log_rr.size(), 4);
      chk("order_fp_n", log_fp.size(), 4);
      for (int i = 0; i < 4 && i < log_rr.size(); i++)
         chk($sformatf("order_rr_%0d", i), log_rr[i], exp_rr[i]);
      for (int i = 0; i < 4 && i < log_fp.size(); i++)
         chk($sformatf("order_fp_%0d", i), log_fp[i], 0);

      // Byte write on s1, zero-wait slave
      tick();
      s1_write = 1; s1_byteenable = 4'b0100; s1_address = 32'h30; s1_writedata = 32'hA5;
      tick(); at_neg();
      chk("be_c1", {m_be[0], m_wr[0], w1[0]}, {4'b0100, 1'b1, 1'b0});
      tick(); s1_write = 0;
      at_neg(); chk("be_c2", {m_wr[0], w1[0]}, 2'b01);

      // Reset mid-transfer while s1 owns a stalled write
      tick();
      s1_write = 1; s1_address = 32'h40; m_waitrequest = 1;
      tick(); at_neg(); chk("mr_c1", m_wr[0], 1'b1);
      tick(); #2 areset = 1'b1; #1;
      chk("mr_drop_rr", {m_wr[0], w1[0]}, 2'b01);
      chk("mr_drop_fp", {m_wr[1], w1[1]}, 2'b01);
      s1_write = 0; s0_read = 1; s1_read = 1;
      s0_address = 32'h50; s1_address = 32'h60; m_waitrequest = 0;
      areset = 1'b0;
      tick(); at_neg();
      chk("mr_tie", {m_addr[0], m_rd[0], w0[0], w1[0]}, {32'h50, 3'b101});
      tick(); s0_read = 0; s1_read = 0;

      // Request withdrawn during a stalled grant
      tick();
      s0_read = 1; s0_address = 32'h70; m_waitrequest = 1;
      tick(); at_neg(); chk("wd_c1", {m_rd[0], w0[0]}, 2'b11);
      tick(); s0_read = 0;
      at_neg(); chk("wd_c2", {m_rd[0], w0[0]}, 2'b01);
      tick();
      s0_read = 1; s1_read = 1; s1_address = 32'h80; m_waitrequest = 0;
      at_neg(); chk("wd_c3_idle", {m_rd[0], w0[0], w1[0]}, 3'b011);
      tick(); at_neg();
      chk("wd_rr_s1", {m_addr[0], w0[0], w1[0]}, {32'h80, 2'b10});
      chk("wd_fp_s0", {m_addr[1], w0[1], w1[1]}, {32'h70, 2'b01});
      tick(); s0_read = 0; s1_read = 0; m_waitrequest = 1;

      // Read and write together pass through unchanged
      tick();
      s0_read = 1; s0_write = 1; m_waitrequest = 0;
      tick(); at_neg(); chk("rw_both", {m_rd[0], m_wr[0], w0[0]}, 3'b110);
      tick(); s0_read = 0; s0_write = 0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/amm_arbiter2.md
AMM_ARBITER2 -- requirements
Module: amm_arbiter2

Interface
REQ-001 SHALL provide parameter P_ROUND_ROBIN, default 1: 1 = round-robin arbitration, 0 = fixed priority with s0 highest.
REQ-002 SHALL provide port aclk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port areset  in  1  asynchronous active-high reset.
REQ-004 SHALL provide ports s0_address, s1_address  in  32  requester byte address.
REQ-005 SHALL provide ports s0_writedata, s1_writedata  in  32  requester write data.
REQ-006 SHALL provide ports s0_byteenable, s1_byteenable  in  4  requester byte lanes.
REQ-007 SHALL provide ports s0_write, s1_write, s0_read, s1_read  in  1  requester commands.
REQ-008 SHALL provide ports s0_readdata, s1_readdata  out  32  read data returned to requester.
REQ-009 SHALL provide ports s0_waitrequest, s1_waitrequest  out  1  requester stall.
REQ-010 SHALL provide ports m_address, m_writedata, m_byteenable, m_write, m_read  out  32/32/4/1/1  shared Avalon-MM master.
REQ-011 SHALL provide ports m_readdata  in  32 and m_waitrequest  in  1  shared slave response.

Function
REQ-012 SHALL implement states IDLE, GNT0, GNT1 (2-bit) plus a 1-bit last-grant register lg.
REQ-013 SHALL define reqN = sN_read | sN_write.
REQ-014 In IDLE, SHALL move to GNT0 if only req0, to GNT1 if only req1; if both, pick the port != lg (P_ROUND_ROBIN=1) or s0 (P_ROUND_ROBIN=0).
REQ-015 On entering GNTn, SHALL set lg <= n.
REQ-016 In IDLE, SHALL drive m_read=0, m_write=0; m_address/m_writedata/m_byteenable SHALL be don't-care and carry s0 values.
REQ-017 In GNTn, SHALL drive m_address, m_writedata, m_byteenable, m_read, m_write combinationally from port n.
REQ-018 sN_waitrequest SHALL be 0 only when state is GNTN and m_waitrequest=0; 1 in all other cases, including IDLE.
REQ-019 s0_readdata and s1_readdata SHALL both equal m_readdata; they are valid only for the port whose waitrequest is 0 during a read.
REQ-020 In GNTn with m_waitrequest=0, SHALL return to IDLE at the next edge, giving exactly one transfer per grant.
REQ-021 In GNTn with reqn=0 (requester protocol violation), SHALL return to IDLE at the next edge without touching lg.
REQ-022 Latency SHALL be: request seen in IDLE at cycle 0, m_read/m_write at cycle 1, earliest completion at cycle 1, IDLE at cycle 2, next grant at cycle 3.
REQ-023 With both ports requesting continuously and P_ROUND_ROBIN=1, grants SHALL strictly alternate.
REQ-024 s0_read & s0_write both high SHALL be forwarded unchanged; resolving it is not this block's job.

Reset
REQ-025 While areset=1, SHALL hold state=IDLE, lg=1 (s0 wins the first tie), m_read=0, m_write=0, sN_waitrequest=1.
REQ-026 areset asserted mid-transfer SHALL drop m_read/m_write immediately (asynchronously) and abandon the transfer; no replay.
REQ-027 After areset deasserts, arbitration SHALL resume at the first rising aclk edge.

Structure
REQ-028 Shared package amm_arb_pkg SHALL hold the state encoding constants (IDLE=0, GNT0=1, GNT1=2).
REQ-029 Sub-module amm_arb_rr_pick (combinational: req[1:0], lg, P_ROUND_ROBIN -> winner, valid) SHALL hold the selection logic; everything else stays flat.

Verification
REQ-030 Single read: s0_read=1, addr 0x100, slave waitrequest 2 cycles, readdata 0xDEADBEEF -> m_read high cycles 1-3, s0_waitrequest=0 in cycle 3 with s0_readdata=0xDEADBEEF, s1_waitrequest=1 throughout.
REQ-031 Simultaneous: s0_write (0x10, data 0x11) and s1_write (0x20, data 0x22) from reset -> s0 served first, then s1 at cycle 3; with both held for 4 transfers, order is s0,s1,s0,s1.
REQ-032 Fixed priority: P_ROUND_ROBIN=0, both requesting continuously -> s0 granted every time, s1 never granted.
REQ-033 Byte write: s1_write, byteenable 4'b0100, zero-wait slave -> m_byteenable=4'b0100 in cycle 1, s1_waitrequest=0 in cycle 1, IDLE in cycle 2.
REQ-034 Reset mid-transfer: areset pulsed while GNT1 with m_waitrequest=1 -> m_write drops in the same cycle, state is IDLE, and the first post-reset tie goes to s0.
REQ-035 Request withdrawn: s0_read deasserted while in GNT0 with m_waitrequest=1 -> state is IDLE at the next edge and lg is unchanged.
